// File: rtl/psec5_ctmp_readout.sv
// psec5_ctmp_readout: captures a CTMP counter snapshot into a 65-bit frame
// and shifts it out MSB first on MISO in the SPI_CLK domain, gated by CS_B.
// A LOAD that arrives while a frame is pending or shifting is dropped. The
// dropped LOAD is remembered as a sticky overflow flag in the next frame header.
module psec5_ctmp_readout #(
    parameter int         DATA_W  = 56,
    parameter logic [2:0] CHAN_ID = 3'd0
) (
    input  logic              SPI_CLK_i,
    input  logic              RSTB_i,
    input  logic              LOAD_i,
    input  logic [DATA_W-1:0] CTMP_i,
    input  logic              CS_B_i,
    output logic              MISO_o,
    output logic              BUSY_o,
    output logic              DONE_o,
    output logic [7:0]        FRAME_CNT_o
);

    localparam int FRAME_W = DATA_W + 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic [6:0]         bitcnt_q, bitcnt_d;
    logic               miso_q, miso_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         frameCnt_q, frameCnt_d;
    logic [FRAME_W-1:0] frameWord;

    // Assemble the frame from the live snapshot: sync nibble, channel, overflow, data, even parity
    always_comb begin
        frameWord = {4'b1010, CHAN_ID, ovf_q, CTMP_i, ^CTMP_i};
    end

    // Next-state logic: capture in IDLE, wait for chip select in ARMED, shift one bit per enabled edge
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        bitcnt_d   = bitcnt_q;
        miso_d     = miso_q;
        ovf_d      = ovf_q;
        frameCnt_d = frameCnt_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (LOAD_i) begin
                    shadow_d = frameWord;
                    bitcnt_d = 7'(FRAME_W - 1);
                    ovf_d    = 1'b0;
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                miso_d = 1'b0;
                if (LOAD_i) begin
                    ovf_d = 1'b1;
                end
                if (!CS_B_i) begin
                    state_d = SHIFT;
                    miso_d  = shadow_q[FRAME_W-1];
                end
            end
            SHIFT: begin
                if (LOAD_i) begin
                    ovf_d = 1'b1;
                end
                if (!CS_B_i) begin
                    if (bitcnt_q != 7'd0) begin
                        bitcnt_d = bitcnt_q - 7'd1;
                        miso_d   = shadow_q[bitcnt_q-7'd1];
                    end else begin
                        state_d    = IDLE;
                        miso_d     = 1'b0;
                        done_d     = 1'b1;
                        frameCnt_d = frameCnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; an asynchronous reset aborts any frame in flight
    always_ff @(posedge SPI_CLK_i or negedge RSTB_i) begin
        if (!RSTB_i) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            bitcnt_q   <= '0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            frameCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            bitcnt_q   <= bitcnt_d;
            miso_q     <= miso_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    assign MISO_o      = miso_q;
    assign BUSY_o      = busy_q;
    assign DONE_o      = done_q;
    assign FRAME_CNT_o = frameCnt_q;

endmodule
